// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: word type, next-PC select encoding and PC-unit states.
package cpu_types_pkg;

   localparam int unsigned WORD_BITS = 32;
   typedef logic [WORD_BITS-1:0] word_t;

   localparam int unsigned PC_STEP = 4;

   typedef enum logic [1:0] {
      PC_SEQ = 2'd0,
      PC_BR  = 2'd1,
      PC_J   = 2'd2,
      PC_JR  = 2'd3
   } pcsrc_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      PENDING = 2'd1,
      HALTED  = 2'd2
   } pc_state_t;

endpackage

// File: rtl/pc_redirect_if.sv
// Signal bundle between the PC redirect unit and its surroundings.
interface pc_redirect_if #(
   parameter int unsigned WORD_W = 32
) (
   input logic CLK
);
   logic              RST;
   logic              PC_WEN;
   logic [1:0]        PCSrc;
   logic              branching;
   logic              jumping;
   logic [WORD_W-1:0] br_target;
   logic [WORD_W-1:0] j_target;
   logic [WORD_W-1:0] jr_target;
   logic              ihit;
   logic              halt;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] npc;
   logic              imemREN;
   logic              redirect_pending;
   logic              redirect_applied;
   logic              misalign_err;

   modport pc_mp (
      input  CLK, RST, PC_WEN, PCSrc, branching, jumping,
             br_target, j_target, jr_target, ihit, halt,
      output pc, npc, imemREN, redirect_pending, redirect_applied, misalign_err
   );

   modport tb (
      input  CLK, pc, npc, imemREN, redirect_pending, redirect_applied, misalign_err,
      output RST, PC_WEN, PCSrc, branching, jumping,
             br_target, j_target, jr_target, ihit, halt
   );

endinterface

// File: rtl/pc_target_mux.sv
// Selects the redirect target by PCSrc, forces word alignment, flags misaligned raw targets.
module pc_target_mux
   import cpu_types_pkg::*;
#(
   parameter int unsigned WORD_W = 32
) (
   input  logic [1:0]        pcsrc,
   input  logic [WORD_W-1:0] br_target,
   input  logic [WORD_W-1:0] j_target,
   input  logic [WORD_W-1:0] jr_target,
   output logic [WORD_W-1:0] target,
   output logic              misaligned
);

   logic [WORD_W-1:0] raw;

   always_comb begin
      raw = '0;
      case (pcsrc_t'(pcsrc))
         PC_BR:   raw = br_target;
         PC_J:    raw = j_target;
         PC_JR:   raw = jr_target;
         default: raw = '0;
      endcase
   end

   assign target     = {raw[WORD_W-1:2], 2'b00};
   assign misaligned = |raw[1:0];

endmodule

// File: rtl/pc_redirect_unit.sv
// Architectural PC owner: applies redirects immediately, or holds a stalled one until PC_WEN.
module pc_redirect_unit
   import cpu_types_pkg::*;
#(
   parameter logic [31:0]  PC_INIT = 32'h00000000,
   parameter int unsigned  WORD_W  = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              PC_WEN,
   input  logic [1:0]        PCSrc,
   input  logic              branching,
   input  logic              jumping,
   input  logic [WORD_W-1:0] br_target,
   input  logic [WORD_W-1:0] j_target,
   input  logic [WORD_W-1:0] jr_target,
   input  logic              ihit,
   input  logic              halt,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] npc,
   output logic              imemREN,
   output logic              redirect_pending,
   output logic              redirect_applied,
   output logic              misalign_err
);

   pc_state_t         state;
   logic [WORD_W-1:0] pend_target;
   logic [WORD_W-1:0] target;
   logic              misaligned;
   logic              redirect_req;

   // ihit is already folded into PC_WEN by the hazard unit
   logic unused_ihit;
   assign unused_ihit = ihit;

   pc_target_mux #(.WORD_W(WORD_W)) u_target_mux (
      .pcsrc      (PCSrc),
      .br_target  (br_target),
      .j_target   (j_target),
      .jr_target  (jr_target),
      .target     (target),
      .misaligned (misaligned)
   );

   assign redirect_req     = (PCSrc != 2'b00) && (branching || jumping);
   assign npc              = pc + WORD_W'(PC_STEP);
   assign imemREN          = (state != HALTED);
   assign redirect_pending = (state == PENDING);

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc               <= WORD_W'(PC_INIT);
         state            <= RUN;
         pend_target      <= '0;
         redirect_applied <= 1'b0;
         misalign_err     <= 1'b0;
      end else begin
         redirect_applied <= 1'b0;
         if (state == HALTED) begin
            state <= HALTED;
         end else if (halt) begin
            state <= HALTED;
         end else if (state == PENDING) begin
            // newer requests are wrong-path; only the captured target is honoured
            if (PC_WEN) begin
               pc               <= pend_target;
               redirect_applied <= 1'b1;
               state            <= RUN;
            end
         end else if (PC_WEN) begin
            if (redirect_req) begin
               pc               <= target;
               redirect_applied <= 1'b1;
               misalign_err     <= misalign_err | misaligned;
            end else begin
               pc <= npc;
            end
         end else if (redirect_req) begin
            pend_target  <= target;
            misalign_err <= misalign_err | misaligned;
            state        <= PENDING;
         end
      end
   end

endmodule
